// File: rtl/mem_bist_ctrl.sv
// rtl/mem_bist_ctrl.sv - march BIST sequencer for a single-port memory (W0, R0, WA, RA).
// Define MEM_BIST_INV_EN to add the inverted-address phases WI/RI before FIN.
module mem_bist_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 9,
  parameter int MEM_SIZE      = 512,
  parameter int READ_LATENCY  = 1,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic                     fail_o,
  output logic                     mem_read_o,
  output logic                     mem_write_o,
  output logic [ADDR_WIDTH-1:0]    mem_addr_o,
  output logic [DATA_WIDTH-1:0]    mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]    mem_rdata_i,
  output logic [ADDR_WIDTH-1:0]    err_addr_o,
  output logic [DATA_WIDTH-1:0]    err_data_o,
  output logic [ERR_CNT_WIDTH-1:0] err_count_o
);

  // Counter must reach MEM_SIZE+READ_LATENCY-1 in read phases, so it is wider than an address.
  localparam int CW = ADDR_WIDTH + $clog2(READ_LATENCY + 1) + 1;
  localparam logic [CW-1:0] LAST_W = CW'(MEM_SIZE - 1);
  localparam logic [CW-1:0] LAST_R = CW'(MEM_SIZE + READ_LATENCY - 1);
  localparam logic [CW-1:0] N_C    = CW'(MEM_SIZE);

  typedef enum logic [2:0] {
    S_IDLE, S_W0, S_R0, S_WA, S_RA, S_FIN
`ifdef MEM_BIST_INV_EN
    , S_WI, S_RI
`endif
  } state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     mem_read_q, mem_read_d;
  logic                     mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic [ADDR_WIDTH-1:0]    err_addr_q, err_addr_d;
  logic [DATA_WIDTH-1:0]    err_data_q, err_data_d;
  logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;

  logic                     pv_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0]    pe_q [READ_LATENCY];
  logic [ADDR_WIDTH-1:0]    pa_q [READ_LATENCY];

  logic [ADDR_WIDTH-1:0]    issue_addr;
  logic [DATA_WIDTH-1:0]    issue_pat;
  logic [DATA_WIDTH-1:0]    exp_in;
  logic                     mismatch;

  function automatic logic [DATA_WIDTH-1:0] addr_pat(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH+ADDR_WIDTH-1:0] w;
    w = {{DATA_WIDTH{1'b0}}, a};
    return w[DATA_WIDTH-1:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_addr_d  = err_addr_q;
    err_data_d  = err_data_q;
    err_count_d = err_count_q;
    exp_in      = '0;
    issue_addr  = '0;
    issue_pat   = '0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d     = S_W0;
          cnt_d       = '0;
          done_d      = 1'b0;
          err_addr_d  = '0;
          err_data_d  = '0;
          err_count_d = '0;
        end
      end
      S_W0, S_WA
`ifdef MEM_BIST_INV_EN
      , S_WI
`endif
      : begin
        if (cnt_q == LAST_W) begin
          cnt_d = '0;
          case (state_q)
            S_W0:    state_d = S_R0;
`ifdef MEM_BIST_INV_EN
            S_WI:    state_d = S_RI;
`endif
            default: state_d = S_RA;
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_R0, S_RA
`ifdef MEM_BIST_INV_EN
      , S_RI
`endif
      : begin
        if (cnt_q == LAST_R) begin
          cnt_d = '0;
          case (state_q)
            S_R0:    state_d = S_WA;
`ifdef MEM_BIST_INV_EN
            S_RA:    state_d = S_WI;
`endif
            default: state_d = S_FIN;
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are derived from the next state so that they leave the chip registered.
    issue_addr = cnt_d[ADDR_WIDTH-1:0];
    issue_pat  = addr_pat(issue_addr);
    case (state_d)
      S_W0: begin
        mem_write_d = 1'b1;
        mem_addr_d  = issue_addr;
        mem_wdata_d = '0;
      end
      S_WA: begin
        mem_write_d = 1'b1;
        mem_addr_d  = issue_addr;
        mem_wdata_d = issue_pat;
      end
`ifdef MEM_BIST_INV_EN
      S_WI: begin
        mem_write_d = 1'b1;
        mem_addr_d  = issue_addr;
        mem_wdata_d = ~issue_pat;
      end
      S_RI,
`endif
      S_R0, S_RA: begin
        if (cnt_d < N_C) begin
          mem_read_d = 1'b1;
          mem_addr_d = issue_addr;
        end
      end
      default: ;
    endcase

    case (state_q)
      S_RA:    exp_in = addr_pat(mem_addr_q);
`ifdef MEM_BIST_INV_EN
      S_RI:    exp_in = ~addr_pat(mem_addr_q);
`endif
      default: exp_in = '0;
    endcase

    mismatch = pv_q[READ_LATENCY-1] && (mem_rdata_i != pe_q[READ_LATENCY-1]);
    if (mismatch) begin
      if (err_count_q == '0) begin
        err_addr_d = pa_q[READ_LATENCY-1];
        err_data_d = mem_rdata_i;
      end
      if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_addr_q  <= '0;
      err_data_q  <= '0;
      err_count_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pv_q[i] <= 1'b0;
        pe_q[i] <= '0;
        pa_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_addr_q  <= err_addr_d;
      err_data_q  <= err_data_d;
      err_count_q <= err_count_d;
      pv_q[0]     <= mem_read_q;
      pe_q[0]     <= exp_in;
      pa_q[0]     <= mem_addr_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pa_q[i] <= pa_q[i-1];
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = done_q && (err_count_q == '0);
  assign fail_o      = done_q && (err_count_q != '0);
  assign mem_read_o  = mem_read_q;
  assign mem_write_o = mem_write_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign err_addr_o  = err_addr_q;
  assign err_data_o  = err_data_q;
  assign err_count_o = err_count_q;

endmodule

// File: doc/mem_bist_ctrl.md
Name: mem_bist_ctrl

Overview:
- Built-in self-test sequencer that sits directly upstream of the single-port memory and drives its clk-domain read/write/addr/data_in interface.
- Runs a fixed march: write zeros to every location, read and verify them, write each location's address pattern, then read and verify that pattern.
- Reports pass/fail, the first failing address and data, and a saturating error count to the host/status logic.

Parameters:
- DATA_WIDTH, 8, memory word width.
- ADDR_WIDTH, 9, memory address width.
- MEM_SIZE, 512, number of locations tested (0..MEM_SIZE-1); need not be a power of two; must be ≤ 2**ADDR_WIDTH.
- READ_LATENCY, 1, cycles from mem_read/mem_addr sampled to mem_rdata valid; must be ≥ 1.
- ERR_CNT_WIDTH, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a test; sampled only in IDLE.
- busy  out  1  high while a test is in progress.
- done  out  1  high from test completion until the next accepted start or rst.
- pass  out  1  done && err_count==0.
- fail  out  1  done && err_count!=0.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data.
- err_addr  out  ADDR_WIDTH  address of the first mismatch.
- err_data  out  DATA_WIDTH  data read at the first mismatch.
- err_count  out  ERR_CNT_WIDTH  mismatch count; saturates at all-ones.

Behaviour:
- Reset: FSM to IDLE. Cleared outputs: busy, done, mem_read, mem_write, mem_addr, mem_wdata, err_addr, err_data, err_count. Compare pipeline flushed.
- Reset mid-test aborts the test. No strobe is asserted on the cycle after rst.
- All memory-side outputs are registered. mem_read and mem_write are never high together.
- FSM states: IDLE -> W0 -> R0 -> WA -> RA -> FIN -> IDLE.
- IDLE: start=1 at edge t causes these changes at t+1:
  - err_* cleared, done=0, busy=1;
  - W0 issues address 0.
- start while busy or in FIN is ignored.
- Write phases (W0, WA): one write per cycle, addresses 0..MEM_SIZE-1 ascending, mem_write=1.
  - W0: mem_wdata=0.
  - WA: mem_wdata = address zero-extended or truncated to DATA_WIDTH (lower bits).
  - After MEM_SIZE-1 is issued, the next cycle begins the following read phase; no idle gap.
- Read phases (R0, RA): one read per cycle, addresses 0..MEM_SIZE-1, mem_read=1.
  - Expected data and address travel through a READ_LATENCY-deep valid/expected/address delay line.
  - mem_rdata is compared when the delay-line valid emerges.
  - After the last read is issued, the state holds with strobes low for READ_LATENCY drain cycles, then advances.
- Mismatch handling:
  - If err_count==0 before the increment, capture err_addr and err_data.
  - err_count increments, saturating at 2**ERR_CNT_WIDTH-1.
  - A mismatch does not stop the test.
- FIN lasts one cycle: busy=0 and done=1 on the following edge, then IDLE. done holds.
- Duration: busy is high for exactly 4*MEM_SIZE + 2*READ_LATENCY + 1 cycles.
- mem_addr and mem_wdata hold their last value when strobes are low.

Optional Feature:
- Macro MEM_BIST_INV_EN.
- Defined: two extra phases, WI and RI, inserted between RA and FIN.
  - WI writes the bitwise inverse of the WA pattern.
  - RI verifies it using the same read/drain rules.
  - busy duration becomes 6*MEM_SIZE + 3*READ_LATENCY + 1 cycles.
- Undefined: WI and RI logic is absent and the sequence is exactly as above.

Test Plan:
- Bench uses a behavioural memory model with defaults: 512 entries, READ_LATENCY=1.
- Clean run: start pulse -> busy high 2051 cycles, then done=1, pass=1, fail=0, err_count=0. No cycle has both strobes high.
- Stuck-at: model forces bit 3 of location 0x0A5 to 1 -> R0 mismatch, then RA mismatch (expected A5, got AD) -> err_addr=0x0A5, err_data=0x08, err_count=2, fail=1.
- Saturation: model returns 0xFF on every read -> err_count=255, err_addr=0x000, err_data=0xFF, fail=1.
- Reset mid-test: rst during R0 at address 0x040 -> next cycle busy=0, done=0, mem_read=0, err_count=0. A subsequent start completes with pass=1.
- Ignored start: extra start pulses at cycles 10 and 1500 of a run -> duration is still 2051 cycles with a single completion. A start during done=1 clears done and restarts.
- MEM_BIST_INV_EN defined: clean run -> busy 3076 cycles, pass=1. WI writes 0xFF to 0x000 and 0xFE to 0x101.
